// File: rtl/sound_event_scheduler.sv
// Fixed-priority (crash > point > flap) arbiter and square-wave note sequencer driving one audio pin.
// Optional macro SOUND_FADE_EN adds a 25 % duty fade over the last quarter of every note.
module sound_event_scheduler #(
   parameter int unsigned FLAP_HALF    = 113636,
   parameter int unsigned POINT_A_HALF = 50607,
   parameter int unsigned POINT_B_HALF = 37907,
   parameter int unsigned CRASH_HALF   = 333333,
   parameter int unsigned NOTE_LEN     = 5000000,
   parameter int unsigned CRASH_LEN    = 20000000,
   parameter int unsigned CNT_W        = 25
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       req_flap,
   input  logic       req_point,
   input  logic       req_crash,
   output logic       audio_out,
   output logic [2:0] grant,
   output logic       busy,
   output logic       locked
);

   typedef enum logic [2:0] {
      S_IDLE, S_FLAP, S_POINT_A, S_POINT_B, S_CRASH, S_LOCKOUT
   } state_t;

   localparam logic [CNT_W-1:0] FLAP_H  = CNT_W'(FLAP_HALF);
   localparam logic [CNT_W-1:0] PA_H    = CNT_W'(POINT_A_HALF);
   localparam logic [CNT_W-1:0] PB_H    = CNT_W'(POINT_B_HALF);
   localparam logic [CNT_W-1:0] CRASH_H = CNT_W'(CRASH_HALF);
   localparam logic [CNT_W-1:0] NOTE_L  = CNT_W'(NOTE_LEN);
   localparam logic [CNT_W-1:0] CRASH_L = CNT_W'(CRASH_LEN);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] tone_q, tone_d;
   logic [CNT_W-1:0] dur_q, dur_d;
   logic             sq_q, sq_d;
   logic             audio_q, audio_d;
   logic [2:0]       grant_q, grant_d;
   logic             busy_q, busy_d;
   logic             locked_q, locked_d;
   logic             enter, cur_note, nxt_note;

   function automatic logic [CNT_W-1:0] half_of(input state_t s);
      case (s)
         S_FLAP:    return FLAP_H;
         S_POINT_A: return PA_H;
         S_POINT_B: return PB_H;
         S_CRASH:   return CRASH_H;
         default:   return FLAP_H;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] len_of(input state_t s);
      return (s == S_CRASH) ? CRASH_L : NOTE_L;
   endfunction

   function automatic logic is_note(input state_t s);
      return (s == S_FLAP) || (s == S_POINT_A) || (s == S_POINT_B) || (s == S_CRASH);
   endfunction

`ifdef SOUND_FADE_EN
   logic [1:0] pwm_q, pwm_d;
   logic       fade;
`endif

   always_comb begin
      state_d  = state_q;
      enter    = 1'b0;
      cur_note = is_note(state_q);

      if (cur_note && dur_q == '0) begin
         case (state_q)
            S_FLAP:    state_d = S_IDLE;
            S_POINT_A: begin state_d = S_POINT_B; enter = 1'b1; end
            S_POINT_B: state_d = S_IDLE;
            S_CRASH:   state_d = S_LOCKOUT;
            default:   state_d = state_q;
         endcase
      end

      // Requests override a coinciding natural note end; losers are simply dropped.
      if (req_crash && state_q != S_CRASH && state_q != S_LOCKOUT) begin
         state_d = S_CRASH;
         enter   = 1'b1;
      end else if (req_point && (state_q == S_IDLE || state_q == S_FLAP ||
                                 state_q == S_POINT_A || state_q == S_POINT_B)) begin
         state_d = S_POINT_A;
         enter   = 1'b1;
      end else if (req_flap && (state_q == S_IDLE || state_q == S_FLAP)) begin
         state_d = S_FLAP;
         enter   = 1'b1;
      end

      nxt_note = is_note(state_d);
      tone_d   = '0;
      dur_d    = '0;
      sq_d     = 1'b0;
      if (enter) begin
         dur_d = len_of(state_d) - 1'b1;
      end else if (nxt_note) begin
         // Not entering but still in a note implies the same note continues.
         dur_d = dur_q - 1'b1;
         if (tone_q == half_of(state_q) - 1'b1) begin
            tone_d = '0;
            sq_d   = ~sq_q;
         end else begin
            tone_d = tone_q + 1'b1;
            sq_d   = sq_q;
         end
      end

      audio_d = sq_d & en;
`ifdef SOUND_FADE_EN
      pwm_d = pwm_q + 2'd1;
      fade  = nxt_note && (dur_d < (len_of(state_d) >> 2));
      if (fade) audio_d = audio_d & (pwm_d == 2'd0);
`endif

      case (state_d)
         S_FLAP:               grant_d = 3'b001;
         S_POINT_A, S_POINT_B: grant_d = 3'b010;
         S_CRASH:              grant_d = 3'b100;
         default:              grant_d = 3'b000;
      endcase
      busy_d   = (state_d != S_IDLE);
      locked_d = (state_d == S_LOCKOUT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         tone_q   <= '0;
         dur_q    <= '0;
         sq_q     <= 1'b0;
         audio_q  <= 1'b0;
         grant_q  <= 3'b000;
         busy_q   <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         tone_q   <= tone_d;
         dur_q    <= dur_d;
         sq_q     <= sq_d;
         audio_q  <= audio_d;
         grant_q  <= grant_d;
         busy_q   <= busy_d;
         locked_q <= locked_d;
      end
   end

`ifdef SOUND_FADE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pwm_q <= 2'd0;
      else     pwm_q <= pwm_d;
   end
`endif

   assign audio_out = audio_q;
   assign grant     = grant_q;
   assign busy      = busy_q;
   assign locked    = locked_q;

endmodule
